// File: rtl/save_state_manager_if.sv
// Save-state word bus between the manager (initiator) and the controller.
// The manager issues one request per 64-bit word and waits for its ack.
interface save_state_manager_if;
    logic        ss_req;
    logic        ss_rnw;
    logic [25:0] ss_addr;
    logic [7:0]  ss_be;
    logic [63:0] ss_din;
    logic [63:0] ss_dout;
    logic        ss_ack;

    modport master (
        output ss_req, ss_rnw, ss_addr, ss_be, ss_din,
        input  ss_dout, ss_ack
    );

    modport slave (
        input  ss_req, ss_rnw, ss_addr, ss_be, ss_din,
        output ss_dout, ss_ack
    );
endinterface

// File: rtl/save_state_manager.sv
// Freezes the core and streams a header plus NUM_WORDS state words
// out to (save) or in from (load) the save-state controller.
module save_state_manager #(
    parameter int          NUM_WORDS = 64,
    parameter logic [15:0] VERSION   = 16'h0001,
    parameter int          TIMEOUT   = 2**20,
    parameter int          AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk_ppu_21_47,
    input  logic                  reset_n,
    input  logic                  ss_save,
    input  logic                  ss_load,
    save_state_manager_if.master  ss,
    output logic                  ss_busy,
    output logic                  core_pause_req,
    input  logic                  core_paused,
    output logic [AW-1:0]         core_addr,
    input  logic [63:0]           core_rdata,
    output logic                  core_wr,
    output logic [63:0]           core_wdata,
    output logic                  ss_done,
    output logic                  ss_err,
    output logic [1:0]            ss_err_code
);

    localparam int          TW     = $clog2(TIMEOUT + 1);
    localparam logic [15:0] LAST   = 16'(NUM_WORDS);
    localparam logic [63:0] HEADER = {32'h4E455353, VERSION, LAST};

    typedef enum logic [3:0] {
        IDLE, PAUSE, S_FETCH, S_LATCH, S_WAIT_ACK,
        L_REQ, L_WAIT_ACK, L_WRITE, FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          req_q, req_d;
    logic          rnw_q, rnw_d;
    logic [25:0]   addr_q, addr_d;
    logic [63:0]   din_q, din_d;
    logic          busy_q, busy_d;
    logic          pause_q, pause_d;
    logic [AW-1:0] caddr_q, caddr_d;
    logic          wr_q, wr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic          finish;
    logic          abort;
    logic [1:0]    abort_code;
    logic          counting;
    logic          tmo_hit;

    assign counting = (state_q == PAUSE) || (state_q == S_WAIT_ACK) ||
                      (state_q == L_WAIT_ACK);
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        req_d      = 1'b0;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        din_d      = din_q;
        busy_d     = busy_q;
        pause_d    = pause_q;
        caddr_d    = caddr_q;
        wr_d       = 1'b0;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        finish     = 1'b0;
        abort      = 1'b0;
        abort_code = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (ss_save || ss_load) begin
                    busy_d  = 1'b1;
                    pause_d = 1'b1;
                    rnw_d   = !ss_save;
                    idx_d   = 16'd0;
                    code_d  = 2'd0;
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (core_paused) begin
                    state_d = rnw_q ? L_REQ : S_FETCH;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    abort_code = 2'd2;
                end
            end
            S_FETCH: begin
                if (idx_q != 16'd0) caddr_d = AW'(idx_q - 16'd1);
                state_d = S_LATCH;
            end
            S_LATCH: begin
                din_d   = (idx_q == 16'd0) ? HEADER : core_rdata;
                addr_d  = {7'd0, idx_q, 3'd0};
                req_d   = 1'b1;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ss.ss_ack) begin
                    if (idx_q == LAST) begin
                        finish = 1'b1;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    abort_code = 2'd2;
                end
            end
            L_REQ: begin
                addr_d  = {7'd0, idx_q, 3'd0};
                req_d   = 1'b1;
                state_d = L_WAIT_ACK;
            end
            L_WAIT_ACK: begin
                if (ss.ss_ack) begin
                    if (idx_q == 16'd0) begin
                        if (ss.ss_dout != HEADER) begin
                            abort      = 1'b1;
                            abort_code = 2'd1;
                        end else begin
                            idx_d   = 16'd1;
                            state_d = L_REQ;
                        end
                    end else begin
                        wdata_d = ss.ss_dout;
                        // controller watches busy fall one cycle after last ack
                        if (idx_q == LAST) busy_d = 1'b0;
                        state_d = L_WRITE;
                    end
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    abort_code = 2'd2;
                end
            end
            L_WRITE: begin
                wr_d    = 1'b1;
                caddr_d = AW'(idx_q - 16'd1);
                if (idx_q == LAST) begin
                    finish = 1'b1;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = L_REQ;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (finish || abort) begin
            busy_d  = 1'b0;
            pause_d = 1'b0;
            done_d  = finish;
            err_d   = abort;
            state_d = FINISH;
        end
        if (abort) code_d = abort_code;
        tmo_d = (counting && state_d == state_q) ? tmo_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_ppu_21_47) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            pause_q <= 1'b0;
            caddr_q <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            pause_q <= pause_d;
            caddr_q <= caddr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign ss.ss_req      = req_q;
    assign ss.ss_rnw      = rnw_q;
    assign ss.ss_addr     = addr_q;
    assign ss.ss_be       = 8'hFF;
    assign ss.ss_din      = din_q;
    assign ss_busy        = busy_q;
    assign core_pause_req = pause_q;
    assign core_addr      = caddr_q;
    assign core_wr        = wr_q;
    assign core_wdata     = wdata_q;
    assign ss_done        = done_q;
    assign ss_err         = err_q;
    assign ss_err_code    = code_q;

endmodule

// File: tb/tb_save_state_manager.sv
// Directed bench for save_state_manager: save, load, header error,
// timeouts, command collisions and mid-operation reset.
module tb_save_state_manager;

    localparam int TMO = 20;
    localparam logic [63:0] HDR = 64'h4E455353_0001_0004;

    logic        clk;
    logic        reset_n;
    logic        ss_save;
    logic        ss_load;
    logic        ss_busy;
    logic        core_pause_req;
    logic        core_paused;
    logic [1:0]  core_addr;
    logic [63:0] core_rdata;
    logic        core_wr;
    logic [63:0] core_wdata;
    logic        ss_done;
    logic        ss_err;
    logic [1:0]  ss_err_code;

    save_state_manager_if ifc ();

    save_state_manager #(
        .NUM_WORDS (4),
        .VERSION   (16'h0001),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_ppu_21_47  (clk),
        .reset_n        (reset_n),
        .ss_save        (ss_save),
        .ss_load        (ss_load),
        .ss             (ifc),
        .ss_busy        (ss_busy),
        .core_pause_req (core_pause_req),
        .core_paused    (core_paused),
        .core_addr      (core_addr),
        .core_rdata     (core_rdata),
        .core_wr        (core_wr),
        .core_wdata     (core_wdata),
        .ss_done        (ss_done),
        .ss_err         (ss_err),
        .ss_err_code    (ss_err_code)
    );

    logic [63:0] mem [4];
    logic [63:0] load_data [5];
    assign core_rdata = mem[core_addr];

    int          ack_dly;
    logic [25:0] skip_addr;
    logic        pause_en;

    int          cyc = 0;
    int          pend = 0;
    logic [2:0]  pend_w = 3'd0;
    logic        prev_busy = 1'b0;
    logic        prev_req = 1'b0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          done_cyc = 0;
    int          err_cyc = 0;
    int          rise_cyc = 0;
    int          fall_cyc = 0;
    int          dbl_req = 0;
    int          save_busy = 0;
    logic [25:0] req_addr_q [$];
    logic [63:0] req_din_q [$];
    logic        req_rnw_q [$];
    int          req_cyc_q [$];
    int          ack_cyc_q [$];
    logic [1:0]  wr_addr_q [$];
    logic [63:0] wr_data_q [$];

    int tests = 0;
    int fails = 0;
    int cmd_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // controller/core model and event log
    always @(posedge clk) begin
        #1;
        cyc++;
        ifc.ss_ack  = 1'b0;
        ifc.ss_dout = 64'd0;
        core_paused = pause_en & core_pause_req;
        if (!reset_n) begin
            pend = 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                ifc.ss_ack  = 1'b1;
                ifc.ss_dout = load_data[pend_w];
                ack_cyc_q.push_back(cyc);
            end
        end
        if (ifc.ss_req) begin
            req_addr_q.push_back(ifc.ss_addr);
            req_din_q.push_back(ifc.ss_din);
            req_rnw_q.push_back(ifc.ss_rnw);
            req_cyc_q.push_back(cyc);
            if (prev_req) dbl_req++;
            if (ifc.ss_addr != skip_addr) begin
                pend   = ack_dly;
                pend_w = ifc.ss_addr[5:3];
            end
        end
        if (core_wr) begin
            wr_addr_q.push_back(core_addr);
            wr_data_q.push_back(core_wdata);
        end
        if (ss_done) begin done_cnt++; done_cyc = cyc; end
        if (ss_err) begin err_cnt++; err_cyc = cyc; end
        if (ss_busy && !prev_busy) rise_cyc = cyc;
        if (!ss_busy && prev_busy) fall_cyc = cyc;
        if (ss_busy && !ifc.ss_rnw) save_busy++;
        prev_busy = ss_busy;
        prev_req  = ifc.ss_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic s, input logic l);
        @(negedge clk);
        ss_save = s;
        ss_load = l;
        cmd_cyc = cyc;
        @(negedge clk);
        ss_save = 1'b0;
        ss_load = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int base = done_cnt + err_cnt;
        int k = 0;
        while (done_cnt + err_cnt == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_end"}, 64'(done_cnt + err_cnt != base), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(ss_busy), 64'd0);
        chk({tag, "_pause"}, 64'(core_pause_req), 64'd0);
        chk({tag, "_req"}, 64'(ifc.ss_req), 64'd0);
        chk({tag, "_rnw"}, 64'(ifc.ss_rnw), 64'd0);
        chk({tag, "_addr"}, 64'(ifc.ss_addr), 64'd0);
        chk({tag, "_din"}, ifc.ss_din, 64'd0);
        chk({tag, "_be"}, 64'(ifc.ss_be), 64'hFF);
        chk({tag, "_wr"}, 64'(core_wr), 64'd0);
        chk({tag, "_caddr"}, 64'(core_addr), 64'd0);
        chk({tag, "_wdata"}, core_wdata, 64'd0);
        chk({tag, "_done"}, 64'(ss_done), 64'd0);
        chk({tag, "_err"}, 64'(ss_err), 64'd0);
        chk({tag, "_code"}, 64'(ss_err_code), 64'd0);
    endtask

    initial begin
        int rb, ab, wb, db, eb, sb, dd, k;
        reset_n   = 1'b0;
        ss_save   = 1'b0;
        ss_load   = 1'b0;
        ack_dly   = 3;
        skip_addr = 26'h3FFFFFF;
        pause_en  = 1'b1;
        mem[0] = 64'hA5A5_0000_1111_0001;
        mem[1] = 64'h5A5A_0000_2222_0002;
        mem[2] = 64'hDEAD_0000_3333_0003;
        mem[3] = 64'hBEEF_0000_4444_0004;
        load_data[0] = HDR;
        load_data[1] = 64'd1;
        load_data[2] = 64'd2;
        load_data[3] = 64'd3;
        load_data[4] = 64'd4;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // save, ack three cycles after each request
        rb = req_addr_q.size(); ab = ack_cyc_q.size();
        wb = wr_addr_q.size(); db = done_cnt;
        cmd(1'b1, 1'b0);
        wait_end(300, "save");
        chk("save_nreq", 64'(req_addr_q.size() - rb), 64'd5);
        if (req_addr_q.size() - rb == 5 && ack_cyc_q.size() - ab == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("save_addr%0d", i), 64'(req_addr_q[rb+i]),
                    64'(i * 8));
                chk($sformatf("save_din%0d", i), req_din_q[rb+i],
                    (i == 0) ? HDR : mem[i-1]);
                chk($sformatf("save_rnw%0d", i), 64'(req_rnw_q[rb+i]), 64'd0);
            end
            for (int i = 0; i < 4; i++)
                chk($sformatf("save_cad%0d", i),
                    64'(req_cyc_q[rb+i+1] - ack_cyc_q[ab+i]), 64'd3);
            chk("save_fall", 64'(fall_cyc), 64'(ack_cyc_q[ab+4] + 1));
            chk("save_donecyc", 64'(done_cyc), 64'(ack_cyc_q[ab+4] + 1));
        end
        chk("save_rise", 64'(rise_cyc), 64'(cmd_cyc + 1));
        chk("save_done", 64'(done_cnt - db), 64'd1);
        chk("save_nwr", 64'(wr_addr_q.size() - wb), 64'd0);

        // load with a good header, ack on the next cycle
        ack_dly = 1;
        rb = req_addr_q.size(); ab = ack_cyc_q.size();
        wb = wr_addr_q.size(); db = done_cnt; eb = err_cnt; sb = save_busy;
        cmd(1'b0, 1'b1);
        wait_end(300, "load");
        chk("load_nreq", 64'(req_addr_q.size() - rb), 64'd5);
        chk("load_nwr", 64'(wr_addr_q.size() - wb), 64'd4);
        if (wr_addr_q.size() - wb == 4)
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("load_waddr%0d", i), 64'(wr_addr_q[wb+i]),
                    64'(i));
                chk($sformatf("load_wdata%0d", i), wr_data_q[wb+i],
                    64'(i + 1));
            end
        if (ack_cyc_q.size() - ab == 5)
            chk("load_fall", 64'(fall_cyc), 64'(ack_cyc_q[ab+4] + 1));
        chk("load_done", 64'(done_cnt - db), 64'd1);
        chk("load_noerr", 64'(err_cnt - eb), 64'd0);
        chk("load_rnw", 64'(save_busy - sb), 64'd0);
        chk("load_pause", 64'(core_pause_req), 64'd0);

        // load with a bad header magic
        load_data[0] = {32'hDEADBEEF, 16'h0001, 16'h0004};
        rb = req_addr_q.size(); wb = wr_addr_q.size();
        db = done_cnt; eb = err_cnt;
        cmd(1'b0, 1'b1);
        wait_end(100, "badhdr");
        chk("badhdr_nreq", 64'(req_addr_q.size() - rb), 64'd1);
        chk("badhdr_nwr", 64'(wr_addr_q.size() - wb), 64'd0);
        chk("badhdr_err", 64'(err_cnt - eb), 64'd1);
        chk("badhdr_done", 64'(done_cnt - db), 64'd0);
        chk("badhdr_code", 64'(ss_err_code), 64'd1);
        chk("badhdr_busy", 64'(ss_busy), 64'd0);
        chk("badhdr_pause", 64'(core_pause_req), 64'd0);
        load_data[0] = HDR;

        // save while the core never pauses
        pause_en = 1'b0;
        rb = req_addr_q.size(); eb = err_cnt;
        cmd(1'b1, 1'b0);
        chk("tmo1_code_clr", 64'(ss_err_code), 64'd1 - 64'd1);
        wait_end(200, "tmo1");
        pause_en = 1'b1;
        dd = err_cyc - cmd_cyc;
        chk("tmo1_err", 64'(err_cnt - eb), 64'd1);
        chk("tmo1_code", 64'(ss_err_code), 64'd2);
        chk("tmo1_nreq", 64'(req_addr_q.size() - rb), 64'd0);
        chk("tmo1_delay", 64'(dd >= TMO && dd <= TMO + 2), 64'd1);
        chk("tmo1_busy", 64'(ss_busy), 64'd0);

        // save with the ack for word 2 withheld
        skip_addr = 26'd16;
        rb = req_addr_q.size(); eb = err_cnt; db = done_cnt;
        cmd(1'b1, 1'b0);
        chk("tmo2_code_clr", 64'(ss_err_code), 64'd0);
        wait_end(300, "tmo2");
        skip_addr = 26'h3FFFFFF;
        chk("tmo2_err", 64'(err_cnt - eb), 64'd1);
        chk("tmo2_code", 64'(ss_err_code), 64'd2);
        chk("tmo2_nreq", 64'(req_addr_q.size() - rb), 64'd3);
        chk("tmo2_done", 64'(done_cnt - db), 64'd0);
        chk("tmo2_pause", 64'(core_pause_req), 64'd0);

        // save and load together, then a stray load mid-save
        ack_dly = 3;
        rb = req_addr_q.size(); wb = wr_addr_q.size(); db = done_cnt;
        sb = save_busy;
        cmd(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        ss_load = 1'b1;
        @(negedge clk);
        ss_load = 1'b0;
        wait_end(300, "both");
        repeat (10) @(negedge clk);
        chk("both_nreq", 64'(req_addr_q.size() - rb), 64'd5);
        for (int i = rb; i < req_rnw_q.size(); i++)
            chk($sformatf("both_rnw%0d", i - rb), 64'(req_rnw_q[i]), 64'd0);
        chk("both_done", 64'(done_cnt - db), 64'd1);
        chk("both_nwr", 64'(wr_addr_q.size() - wb), 64'd0);
        chk("both_busy", 64'(ss_busy), 64'd0);

        // reset while waiting for the ack of word 2
        ack_dly = 6;
        rb = req_addr_q.size(); db = done_cnt; eb = err_cnt;
        cmd(1'b1, 1'b0);
        k = 0;
        while (req_addr_q.size() - rb < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach", 64'(req_addr_q.size() - rb), 64'd3);
        reset_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_nreq", 64'(req_addr_q.size() - rb), 64'd3);
        chk("rst_nodone", 64'(done_cnt - db + err_cnt - eb), 64'd0);

        ack_dly = 2;
        rb = req_addr_q.size(); db = done_cnt;
        cmd(1'b1, 1'b0);
        wait_end(300, "after_rst");
        chk("after_rst_nreq", 64'(req_addr_q.size() - rb), 64'd5);
        chk("after_rst_done", 64'(done_cnt - db), 64'd1);
        if (req_din_q.size() - rb == 5)
            chk("after_rst_din4", req_din_q[rb+4], mem[3]);

        chk("no_dbl_req", 64'(dbl_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
